actigraphy_counts_mc: RTL and testbench
=======================================

ACTIGRAPHY_COUNTS_MC -- requirements
Module: actigraphy_counts_mc

Interface
REQ-001 Parameter N_CH, default 3, number of accelerometer axes (1..3).
REQ-002 Parameter DATA_W, default 8, signed sample width per axis.
REQ-003 Parameter PEAK_WINDOW, default 50, valid samples per peak window (1 s at 50 Hz).
REQ-004 Parameter EPOCH_LEN, default 15, peak windows per epoch.
REQ-005 Parameter BIAS, default 18, unsigned value subtracted from the epoch sum.
REQ-006 Parameter SCALE, default 64, unsigned 8-bit Q2.6 gain (64 = 1.0).
REQ-007 Parameter OUT_W, default 8, output count width.
REQ-008 clk  input  1  sole clock; all state updates on the rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 i_accel  input  N_CH*DATA_W  signed, pre-filtered samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 i_valid  input  1  qualifies i_accel for one cycle.
REQ-012 i_mode  input  1  channel combine mode: 0 = max across channels, 1 = sum across channels.
REQ-013 i_sync  input  1  one-cycle pulse restarting window and epoch alignment.
REQ-014 o_count  output  OUT_W  epoch activity count.
REQ-015 o_valid  output  1  one-cycle pulse qualifying o_count.
REQ-016 o_sat  output  1  high with o_valid when the result exceeded 2^OUT_W-1.

Function
REQ-017 Per-channel magnitude SHALL be |x|, with the most negative code mapped to 2^(DATA_W-1)-1 (-128 -> 127).
REQ-018 Each channel SHALL hold a running peak of its magnitude over the current window; the first sample of a window overwrites the peak.
REQ-019 A window counter SHALL count valid samples 0..PEAK_WINDOW-1 and wrap to 0 on the last one.
REQ-020 Stage 1: one cycle after the last valid sample of a window, the combined peak (max or sum per i_mode, width DATA_W+1) SHALL be registered with a one-cycle window-done pulse.
REQ-021 i_mode SHALL be sampled only on the last-sample cycle of a window; mid-window changes have no effect on that window until then.
REQ-022 Stage 2: an epoch accumulator of width DATA_W+1+clog2(EPOCH_LEN)+1 SHALL add each combined peak; on the EPOCH_LEN-th window-done it SHALL latch the final sum, clear, and pulse epoch-done.
REQ-023 Stage 3: result = max(sum - BIAS, 0) * SCALE >> 6, registered to o_count with o_valid.
REQ-024 Total latency: o_valid SHALL assert exactly 3 cycles after the i_valid cycle carrying the final sample of an epoch.
REQ-025 i_sync SHALL zero the window counter, epoch counter, peaks and accumulator; i_valid in the same cycle SHALL be taken as sample 0 of the new window.
REQ-026 Pipeline pulses already in stages 1-3 SHALL complete despite i_sync.
REQ-027 Samples with i_valid low SHALL not change any counter or peak.
REQ-028 No back-pressure; o_valid pulses are never stalled or dropped.

Reset
REQ-029 reset SHALL clear all counters, peaks, the accumulator, and all pipeline registers.
REQ-030 During and on the cycle after reset: o_count = 0, o_valid = 0, o_sat = 0.
REQ-031 Reset mid-epoch SHALL discard the partial epoch; the next o_valid follows a full PEAK_WINDOW*EPOCH_LEN samples after reset release.

Configuration
REQ-032 Macro ACTI_COUNT_SATURATE_EN defined: results above 2^OUT_W-1 SHALL clamp to 2^OUT_W-1 with o_sat = 1.
REQ-033 Macro undefined: o_count SHALL be the low OUT_W bits of the result (wrap) and o_sat SHALL be tied 0.

Verification
REQ-034 Defaults, mode 0, z = 10 constant, x = y = 0, 750 valid samples -> single o_valid 3 cycles after sample 750, o_count = 132.
REQ-035 Defaults, mode 1, x = y = z = 10, 750 samples -> result 432: o_count = 255, o_sat = 1 with macro; o_count = 176, o_sat = 0 without.
REQ-036 All channels -128 constant, mode 0 -> peak 127, o_count = 1887 saturated to 255 (macro on).
REQ-037 z = 1 constant, mode 0 -> sum 15 < BIAS -> o_count = 0, o_valid still pulses.
REQ-038 reset asserted at sample 400 then 750 fresh samples of z = 10 -> no o_valid before sample 750 after release, then o_count = 132.
REQ-039 i_sync with i_valid at sample 300 -> that sample counts as 0; o_valid 3 cycles after the 750th sample from the sync.

Source files
------------

// File: rtl/actigraphy_counts_mc.sv
// ---------------------------------------------------------------------------
// actigraphy_counts_mc
//
// Purpose
//   Turns a stream of pre-filtered, signed multi-axis accelerometer samples
//   into epoch activity counts, in three pipeline stages:
//     stage 0 : per-channel |x| and a running peak over each peak window.
//     stage 1 : on the last sample of a window, the channel peaks are
//               combined (max or sum) and registered with a window-done pulse.
//     stage 2 : the combined peaks of EPOCH_LEN windows are accumulated. The
//               final sum is latched with an epoch-done pulse.
//     stage 3 : result = max(sum - BIAS, 0) * SCALE >> 6 goes to o_count
//               together with o_valid.
//   o_valid rises exactly 3 cycles after the i_valid cycle that carried the
//   final sample of an epoch.
//
// Handshake
//   i_valid qualifies i_accel (and i_mode on a window's last sample) for that
//   one cycle only. There is no back-pressure in either direction. o_valid is
//   a one-cycle pulse that is never stalled or dropped. o_count holds its
//   value between pulses.
//
// Configuration
//   ACTI_COUNT_SATURATE_EN : when defined, results above 2^OUT_W-1 clamp to
//   2^OUT_W-1 and raise o_sat with o_valid. When undefined, o_count is the
//   low OUT_W bits of the result and o_sat is tied low.
//
// Ports
//   clk      in   1            sole clock, rising edge
//   reset    in   1            synchronous, active-high
//   i_accel  in   N_CH*DATA_W  signed samples, channel k at [k*DATA_W +: DATA_W]
//   i_valid  in   1            sample qualifier
//   i_mode   in   1            0 = max across channels, 1 = sum across channels
//   i_sync   in   1            restart window/epoch alignment (pulse)
//   o_count  out  OUT_W        epoch activity count
//   o_valid  out  1            qualifies o_count (one-cycle pulse)
//   o_sat    out  1            result exceeded 2^OUT_W-1 (with o_valid)
// ---------------------------------------------------------------------------
module actigraphy_counts_mc #(
    parameter int N_CH        = 3,
    parameter int DATA_W      = 8,
    parameter int PEAK_WINDOW = 50,
    parameter int EPOCH_LEN   = 15,
    parameter int BIAS        = 18,
    parameter int SCALE       = 64,
    parameter int OUT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH*DATA_W-1:0] i_accel,
    input  logic                   i_valid,
    input  logic                   i_mode,
    input  logic                   i_sync,
    output logic [OUT_W-1:0]       o_count,
    output logic                   o_valid,
    output logic                   o_sat
);

    localparam int CW    = DATA_W + 1;
    localparam int ACC_W = DATA_W + 1 + $clog2(EPOCH_LEN) + 1;
    localparam int WIN_W = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;
    localparam int EP_W  = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam int PRD_W = ACC_W + 8;
    localparam int RES_W = PRD_W - 6;
    localparam int RW    = (RES_W > OUT_W) ? RES_W : OUT_W + 1;

    localparam logic [7:0]        SCALE_Q  = SCALE[7:0];
    localparam logic [ACC_W-1:0]  BIAS_Q   = ACC_W'(BIAS);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(PEAK_WINDOW - 1);
    localparam logic [EP_W-1:0]   EP_LAST  = EP_W'(EPOCH_LEN - 1);

    // ------------------------------------------------------------------
    // Stage 0: magnitudes and running peaks
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mag  [N_CH];
    logic [DATA_W-1:0] cand [N_CH];
    logic [DATA_W-1:0] peak [N_CH];
    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_pos;
    logic              win_first;
    logic              win_last;
    logic [CW-1:0]     comb_max;
    logic [CW-1:0]     comb_sum;
    logic [CW-1:0]     comb_val;

    // i_sync makes this cycle's sample position 0 of a fresh window.
    assign win_pos   = i_sync ? '0 : win_cnt;
    assign win_first = (win_pos == '0);
    assign win_last  = (win_pos == WIN_LAST);

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            logic [DATA_W-1:0] s;
            s = i_accel[k*DATA_W +: DATA_W];
            mag[k] = s;
            if (s[DATA_W-1]) begin
                // Most negative code has no positive twin; pin it to max positive.
                if (s == {1'b1, {(DATA_W-1){1'b0}}})
                    mag[k] = {1'b0, {(DATA_W-1){1'b1}}};
                else
                    mag[k] = ~s + DATA_W'(1);
            end
        end
    end

    // Candidate peak includes the current sample, so the window's last sample
    // takes part in the combined value without an extra cycle.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cand[k] = mag[k];
            if (!win_first && (peak[k] > mag[k]))
                cand[k] = peak[k];
        end
    end

    always_comb begin
        comb_max = '0;
        comb_sum = '0;
        for (int k = 0; k < N_CH; k++) begin
            comb_sum = comb_sum + CW'(cand[k]);
            if (CW'(cand[k]) > comb_max)
                comb_max = CW'(cand[k]);
        end
        comb_val = i_mode ? comb_sum : comb_max;
    end

    // ------------------------------------------------------------------
    // Stage 0 state + stage 1 register
    // ------------------------------------------------------------------
    logic          win_done;
    logic [CW-1:0] win_peak;

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt  <= '0;
            win_done <= 1'b0;
            win_peak <= '0;
            for (int k = 0; k < N_CH; k++)
                peak[k] <= '0;
        end else begin
            win_done <= 1'b0;
            if (i_valid) begin
                for (int k = 0; k < N_CH; k++)
                    peak[k] <= cand[k];
                if (win_last) begin
                    win_cnt  <= '0;
                    win_done <= 1'b1;
                    win_peak <= comb_val;
                end else begin
                    win_cnt <= win_pos + WIN_W'(1);
                end
            end else if (i_sync) begin
                win_cnt <= '0;
                for (int k = 0; k < N_CH; k++)
                    peak[k] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: epoch accumulator
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [EP_W-1:0]  ep_cnt;
    logic             ep_end;
    logic             ep_done;
    logic [ACC_W-1:0] ep_sum;

    assign acc_next = acc + ACC_W'(win_peak);
    assign ep_end   = win_done && (ep_cnt == EP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            ep_cnt  <= '0;
            ep_done <= 1'b0;
            ep_sum  <= '0;
        end else begin
            ep_done <= 1'b0;
            // A completing epoch finishes even when i_sync lands on the same
            // cycle; a non-final window pulse under i_sync belongs to the
            // abandoned alignment and is dropped.
            if (ep_end) begin
                ep_sum  <= acc_next;
                ep_done <= 1'b1;
            end
            if (i_sync || ep_end) begin
                acc    <= '0;
                ep_cnt <= '0;
            end else if (win_done) begin
                acc    <= acc_next;
                ep_cnt <= ep_cnt + EP_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: bias, gain, output register
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] diff;
    logic [PRD_W-1:0] prod;
    logic [RW-1:0]    res_w;
    logic [OUT_W-1:0] count_c;
    logic             sat_c;
    logic             unused_bits;

    assign diff  = (ep_sum > BIAS_Q) ? (ep_sum - BIAS_Q) : '0;
    assign prod  = PRD_W'(diff) * PRD_W'(SCALE_Q);
    // Q2.6 gain: drop the six fraction bits.
    assign res_w = RW'(prod[PRD_W-1:6]);
    assign unused_bits = ^{prod[5:0], res_w[RW-1:OUT_W]};

`ifdef ACTI_COUNT_SATURATE_EN
    assign sat_c   = |res_w[RW-1:OUT_W];
    assign count_c = sat_c ? {OUT_W{1'b1}} : res_w[OUT_W-1:0];
`else
    assign sat_c   = 1'b0;
    assign count_c = res_w[OUT_W-1:0];
`endif

    logic sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_count <= '0;
            o_valid <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            o_valid <= ep_done;
            sat_q   <= ep_done & sat_c;
            if (ep_done)
                o_count <= count_c;
        end
    end

`ifdef ACTI_COUNT_SATURATE_EN
    assign o_sat = sat_q;
`else
    assign o_sat = 1'b0;
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_actigraphy_counts_mc.sv
// ---------------------------------------------------------------------------
// tb_actigraphy_counts_mc
//
// Bench for actigraphy_counts_mc with default parameters. Each test task
// drives samples and, on the final sample of an epoch, pushes the expected
// {sat,count} and the expected o_valid cycle into queues. A negedge monitor
// pops and compares whenever o_valid is seen. Expectations depend on whether
// ACTI_COUNT_SATURATE_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_actigraphy_counts_mc;

    localparam int N_CH   = 3;
    localparam int DATA_W = 8;
    localparam int PW     = 50;
    localparam int EL     = 15;
    localparam int OUT_W  = 8;

    logic                   clk;
    logic                   reset;
    logic [N_CH*DATA_W-1:0] i_accel;
    logic                   i_valid;
    logic                   i_mode;
    logic                   i_sync;
    logic [OUT_W-1:0]       o_count;
    logic                   o_valid;
    logic                   o_sat;

    actigraphy_counts_mc dut (
        .clk     (clk),
        .reset   (reset),
        .i_accel (i_accel),
        .i_valid (i_valid),
        .i_mode  (i_mode),
        .i_sync  (i_sync),
        .o_count (o_count),
        .o_valid (o_valid),
        .o_sat   (o_sat)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- scoreboard ----------------
    logic [OUT_W:0] exp_q[$];
    int             cyc_q[$];

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_o_valid: got count=%0d at cycle %0d, required no pulse", o_count, cyc);
            end else begin
                logic [OUT_W:0] e;
                int             ec;
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                n_assert++;
                if (o_count !== e[OUT_W-1:0]) begin
                    n_fail++;
                    $display("FAIL epoch_count: got %0d, required %0d", o_count, e[OUT_W-1:0]);
                end
                n_assert++;
                if (o_sat !== e[OUT_W]) begin
                    n_fail++;
                    $display("FAIL epoch_sat: got %0b, required %0b", o_sat, e[OUT_W]);
                end
                n_assert++;
                if (cyc !== ec) begin
                    n_fail++;
                    $display("FAIL epoch_latency: o_valid at cycle %0d, required %0d", cyc, ec);
                end
            end
        end
    end

    // ---------------- reference helpers ----------------
    function automatic logic [OUT_W:0] expect_of(input int sum);
        int d;
        int r;
        d = (sum > 18) ? sum - 18 : 0;
        r = (d * 64) >> 6;
`ifdef ACTI_COUNT_SATURATE_EN
        if (r > 255) return {1'b1, 8'hFF};
`endif
        return {1'b0, 8'(r % 256)};
    endfunction

    function automatic int mag8(input logic [7:0] v);
        if (v == 8'h80) return 127;
        if (v[7]) return 256 - int'(v);
        return int'(v);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] z, input logic m, input logic s,
                         input logic last, input logic [OUT_W:0] e);
        @(posedge clk);
        #1;
        i_valid = v;
        i_accel = {z, y, x};
        i_mode  = m;
        i_sync  = s;
        if (last) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc + 3);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // A full constant epoch; expected value pushed on the final sample.
    task automatic run_epoch(input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] z, input logic m, input logic [OUT_W:0] e);
        for (int i = 0; i < PW*EL; i++)
            drive(1'b1, x, y, z, m, 1'b0, i == PW*EL-1, e);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset   = 1'b1;
        i_valid = 1'b0;
        i_accel = '0;
        i_mode  = 1'b0;
        i_sync  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_accel = {8'd100, 8'd100, 8'd100};
        @(negedge clk);
        n_assert++;
        if (o_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", o_count); end
        n_assert++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", o_valid); end
        n_assert++;
        if (o_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b, required 0", o_sat); end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        n_assert++;
        if (o_count !== 8'd0) begin n_fail++; $display("FAIL post_reset_count: got %0d, required 0", o_count); end
        n_assert++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %0b, required 0", o_valid); end
        n_assert++;
        if (o_sat !== 1'b0) begin n_fail++; $display("FAIL post_reset_sat: got %0b, required 0", o_sat); end
    endtask

    task automatic test_max_mode();
        run_epoch(8'd0, 8'd0, 8'd10, 1'b0, expect_of(150));    // 132
        idle(4);
        run_epoch(8'h80, 8'h80, 8'h80, 1'b0, expect_of(1905)); // 1887
        idle(4);
        run_epoch(8'd0, 8'd0, 8'd1, 1'b0, expect_of(15));      // below bias -> 0
        idle(4);
    endtask

    task automatic test_sum_mode();
        run_epoch(8'd10, 8'd10, 8'd10, 1'b1, expect_of(450));  // 432
        idle(4);
        run_epoch(8'hF6, 8'd3, 8'hFB, 1'b1, expect_of(270));   // |-10|+3+|-5| = 18
        idle(4);
    endtask

    // i_mode is only looked at on a window's last sample.
    task automatic test_mode_midwindow();
        for (int i = 0; i < PW*EL; i++)
            drive(1'b1, 8'd10, 8'd10, 8'd10, (i % PW) != PW-1, 1'b0,
                  i == PW*EL-1, expect_of(150));
        idle(4);
        for (int i = 0; i < PW*EL; i++)
            drive(1'b1, 8'd10, 8'd10, 8'd10, (i % PW) == PW-1, 1'b0,
                  i == PW*EL-1, expect_of(450));
        idle(4);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 400; i++)
            drive(1'b1, 8'd0, 8'd0, 8'd10, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        i_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_assert++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %0b, required 0", o_valid); end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_epoch(8'd0, 8'd0, 8'd10, 1'b0, expect_of(150));
        idle(4);
    endtask

    task automatic test_sync();
        // Stale mid-window history at a different level must be discarded.
        for (int i = 0; i < 310; i++)
            drive(1'b1, 8'd0, 8'd0, 8'd50, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 8'd0, 8'd0, 8'd10, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 1; i < PW*EL; i++)
            drive(1'b1, 8'd0, 8'd0, 8'd10, 1'b0, 1'b0, i == PW*EL-1, expect_of(150));
        idle(4);
    endtask

    // Epochs without gaps; i_sync right after a final sample must not kill it.
    task automatic test_back_to_back();
        run_epoch(8'd0, 8'd0, 8'd10, 1'b0, expect_of(150));
        drive(1'b1, 8'd10, 8'd10, 8'd10, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 1; i < PW*EL; i++)
            drive(1'b1, 8'd10, 8'd10, 8'd10, 1'b1, 1'b0, i == PW*EL-1, expect_of(450));
        run_epoch(8'd0, 8'd0, 8'd1, 1'b0, expect_of(15));
        run_epoch(8'd20, 8'd0, 8'd0, 1'b0, expect_of(300));
        idle(4);
    endtask

    // Random samples, random gaps carrying junk with i_valid low, random mode.
    task automatic test_random_gaps();
        int pk[3];
        int epsum;
        int comb;
        int mx;
        logic [7:0] s[3];
        logic m;
        epsum = 0;
        for (int w = 0; w < EL; w++) begin
            for (int i = 0; i < PW; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++)
                    drive(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
                for (int k = 0; k < 3; k++) begin
                    s[k] = 8'($urandom_range(0, 255));
                    if (i == 0 || mag8(s[k]) > pk[k]) pk[k] = mag8(s[k]);
                end
                m = 1'($urandom_range(0, 1));
                if (i == PW-1) begin
                    mx = pk[0];
                    if (pk[1] > mx) mx = pk[1];
                    if (pk[2] > mx) mx = pk[2];
                    comb  = m ? pk[0] + pk[1] + pk[2] : mx;
                    epsum = epsum + comb;
                end
                drive(1'b1, s[0], s[1], s[2], m, 1'b0,
                      (w == EL-1) && (i == PW-1), expect_of(epsum));
            end
        end
        idle(4);
    endtask

    // ---------------- main ----------------
    initial begin
        test_reset();
        test_max_mode();
        test_sum_mode();
        test_mode_midwindow();
        test_reset_mid();
        test_sync();
        test_back_to_back();
        test_random_gaps();
        idle(10);
        n_assert++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL missing_o_valid: %0d expected epochs never produced, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
